// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell with a registered carry, LSB first.
// Define SERIAL_ADDER_OVF_EN to add the signed-overflow output Overflow.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             Start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             Cin,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Sum,
   output logic             Carry
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             Overflow
`endif
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] s_sr_q, s_sr_d;
   logic             cy_q, cy_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             bit_sum, bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   assign bit_sum   = a_sr_q[0] ^ b_sr_q[0] ^ cy_q;
   assign bit_carry = (a_sr_q[0] & b_sr_q[0]) | (cy_q & (a_sr_q[0] ^ b_sr_q[0]));

   always_comb begin
      state_d = state_q;
      a_sr_d  = a_sr_q;
      b_sr_d  = b_sr_q;
      s_sr_d  = s_sr_q;
      cy_d    = cy_q;
      cnt_d   = cnt_q;
      sum_d   = sum_q;
      carry_d = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_d   = ovf_q;
`endif
      case (state_q)
         // DONE accepts a new Start exactly like IDLE so adds can run back to back
         IDLE, DONE: begin
            if (Start) begin
               a_sr_d  = A;
               b_sr_d  = B;
               cy_d    = Cin;
               cnt_d   = '0;
               state_d = RUN;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            s_sr_d = {bit_sum, s_sr_q[WIDTH-1:1]};
            a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
            cy_d   = bit_carry;
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               sum_d   = {bit_sum, s_sr_q[WIDTH-1:1]};
               carry_d = bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
               // cy_q holds the carry into the MSB on this final bit
               ovf_d   = cy_q ^ bit_carry;
`endif
               state_d = DONE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_sr_q  <= '0;
         b_sr_q  <= '0;
         s_sr_q  <= '0;
         cy_q    <= 1'b0;
         cnt_q   <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_sr_q  <= a_sr_d;
         b_sr_q  <= b_sr_d;
         s_sr_q  <= s_sr_d;
         cy_q    <= cy_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign Busy  = (state_q == RUN);
   assign Done  = (state_q == DONE);
   assign Sum   = sum_q;
   assign Carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
   assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: scoreboard of expected results plus a
// cycle model of Busy/Done, and separate WIDTH=2 and WIDTH=64 instances.
module tb_serial_adder;

   localparam int W = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  a = '0, b = '0;
   logic          cin = 1'b0;
   logic          busy, done, carry;
   logic [W-1:0]  sum;

   logic          start2 = 1'b0, cin2 = 1'b0, busy2, done2, carry2;
   logic [1:0]    a2 = '0, b2 = '0, sum2;
   logic          start64 = 1'b0, cin64 = 1'b0, busy64, done64, carry64;
   logic [63:0]   a64 = '0, b64 = '0, sum64;
`ifdef SERIAL_ADDER_OVF_EN
   logic          ovf, ovf2, ovf64;
`endif

   serial_adder #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .Start(start), .A(a), .B(b), .Cin(cin),
      .Busy(busy), .Done(done), .Sum(sum), .Carry(carry)
`ifdef SERIAL_ADDER_OVF_EN
      , .Overflow(ovf)
`endif
   );

   serial_adder #(.WIDTH(2)) dut2 (
      .clk(clk), .rst(rst), .Start(start2), .A(a2), .B(b2), .Cin(cin2),
      .Busy(busy2), .Done(done2), .Sum(sum2), .Carry(carry2)
`ifdef SERIAL_ADDER_OVF_EN
      , .Overflow(ovf2)
`endif
   );

   serial_adder #(.WIDTH(64)) dut64 (
      .clk(clk), .rst(rst), .Start(start64), .A(a64), .B(b64), .Cin(cin64),
      .Busy(busy64), .Done(done64), .Sum(sum64), .Carry(carry64)
`ifdef SERIAL_ADDER_OVF_EN
      , .Overflow(ovf64)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] sum;
      logic         carry;
      logic         ovf;
      int           k;
   } exp_t;

   typedef enum {M_IDLE, M_RUN, M_DONE} mstate_t;

   exp_t         sb[$];
   mstate_t      mstate = M_IDLE;
   int           mcnt = 0;
   int           cyc = 0;
   logic [W-1:0] msum = '0;
   logic         mcarry = 1'b0;
   logic         movf = 1'b0;
   int           compared = 0;
   int           mismatched = 0;
   int           doneCount = 0;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      compared++;
      if (obs !== expv) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, expv, $time);
      end
   endtask

   // Reference model: predicts acceptance, completion and the held result
   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         mstate = M_IDLE;
         mcnt   = 0;
         sb.delete();
         msum   = '0;
         mcarry = 1'b0;
         movf   = 1'b0;
      end else begin
         case (mstate)
            M_IDLE, M_DONE: begin
               if (start) begin
                  exp_t e;
                  logic [W:0] full;
                  full    = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
                  e.sum   = full[W-1:0];
                  e.carry = full[W];
                  e.ovf   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
                  e.k     = cyc;
                  sb.push_back(e);
                  mstate  = M_RUN;
                  mcnt    = 0;
               end else begin
                  mstate = M_IDLE;
               end
            end
            M_RUN: begin
               if (mcnt == W - 1) begin
                  if (sb.size() > 0) begin
                     msum   = sb[0].sum;
                     mcarry = sb[0].carry;
                     movf   = sb[0].ovf;
                  end
                  mstate = M_DONE;
               end
               mcnt++;
            end
            default: mstate = M_IDLE;
         endcase
      end
   end

   // Output checker, sampled on the falling edge
   initial begin
      int busyRun;
      busyRun = 0;
      forever begin
         @(negedge clk);
         if (rst) begin
            busyRun = 0;
         end else begin
            checkOutput("busy", busy, mstate == M_RUN);
            checkOutput("done", done, mstate == M_DONE);
            checkOutput("sum_hold", sum, msum);
            checkOutput("carry_hold", carry, mcarry);
            if (busy) begin
               busyRun++;
            end else if (busyRun > 0) begin
               checkOutput("busy_len", busyRun, W);
               busyRun = 0;
            end
            if (done) begin
               doneCount++;
               if (sb.size() == 0) begin
                  checkOutput("done_unexpected", 1, 0);
               end else begin
                  exp_t e;
                  e = sb.pop_front();
                  checkOutput("sum", sum, e.sum);
                  checkOutput("carry", carry, e.carry);
                  checkOutput("done_edge_offset", cyc - e.k, W);
`ifdef SERIAL_ADDER_OVF_EN
                  checkOutput("overflow", ovf, e.ovf);
`endif
               end
            end
         end
      end
   end

   task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv);
      @(negedge clk);
      a     = av;
      b     = bv;
      cin   = cv;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      a     = $urandom();
      b     = $urandom();
      cin   = 1'($urandom_range(0, 1));
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((mstate != M_IDLE || sb.size() != 0) && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) checkOutput("idle_timeout", 0, 1);
   endtask

   initial begin
      int n, d0;
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, compared %0d", compared);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n, d0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_busy", busy, 0);
      checkOutput("reset_done", done, 0);
      checkOutput("reset_sum", sum, 0);
      checkOutput("reset_carry", carry, 0);
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput("reset_ovf", ovf, 0);
`endif
      @(negedge clk);
      #1 rst = 1'b0;

      applyStimulus(8'h5A, 8'h33, 1'b0);
      waitIdle();
      applyStimulus(8'hFF, 8'h01, 1'b0);
      waitIdle();
      applyStimulus(8'hFF, 8'hFF, 1'b1);
      waitIdle();

      // Start pulsed during RUN must be ignored
      d0 = doneCount;
      applyStimulus(8'h10, 8'h20, 1'b0);
      repeat (2) @(negedge clk);
      a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      waitIdle();
      checkOutput("ignored_start_sum", sum, 8'h30);
      checkOutput("ignored_start_dones", doneCount - d0, 1);

      // Start held high: back-to-back adds
      d0 = doneCount;
      @(negedge clk);
      a = 8'h0F; b = 8'hF0; cin = 1'b1; start = 1'b1;
      repeat (27) @(negedge clk);
      start = 1'b0;
      waitIdle();
      checkOutput("held_start_dones", doneCount - d0, 3);

      // Asynchronous reset mid-RUN
      d0 = doneCount;
      applyStimulus(8'h11, 8'h22, 1'b0);
      repeat (3) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      checkOutput("async_busy", busy, 0);
      checkOutput("async_done", done, 0);
      checkOutput("async_sum", sum, 0);
      checkOutput("async_carry", carry, 0);
`ifdef SERIAL_ADDER_OVF_EN
      checkOutput("async_ovf", ovf, 0);
`endif
      @(posedge clk);
      @(negedge clk);
      #1 rst = 1'b0;
      checkOutput("async_no_done", doneCount - d0, 0);
      applyStimulus(8'h07, 8'h09, 1'b0);
      waitIdle();
      checkOutput("post_reset_sum", sum, 8'h10);

      // WIDTH=2 instance
      @(negedge clk);
      a2 = 2'b11; b2 = 2'b00; cin2 = 1'b1; start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 0;
      while (!done2 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("w2_done_offset", n, 2);
      checkOutput("w2_sum", sum2, 0);
      checkOutput("w2_carry", carry2, 1);

      // WIDTH=64 instance
      @(negedge clk);
      a64 = '1; b64 = '0; cin64 = 1'b1; start64 = 1'b1;
      @(negedge clk);
      start64 = 1'b0;
      n = 0;
      while (!done64 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("w64_done_offset", n, 64);
      checkOutput("w64_sum", sum64, 0);
      checkOutput("w64_carry", carry64, 1);

      repeat (3) @(negedge clk);
      checkOutput("scoreboard_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
